// File: rtl/midi_voice_alloc.sv
// MIDI note-on/off to voice keystate updates for the ADSR envelope stage.
// Build option: define VOICE_STEAL_EN to steal the oldest voice when none is free.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 16,
  parameter int AGE_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_midi_valid,
  output logic       o_midi_ready,
  input  logic       i_midi_note_on,
  input  logic [6:0] i_midi_note,
  input  logic [6:0] i_midi_velocity,
  input  logic [1:0] i_pipeline_state,
  output logic       o_note_flag,
  output logic       o_note_status,
  output logic [7:0] o_voice_index,
  output logic [6:0] o_note_num,
  output logic       o_overflow,
  output logic [1:0] o_fsm_state
);
  localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  // Handshake: a message transfers on a rising edge where i_midi_valid and
  // o_midi_ready are both high; ready is high only in IDLE, so upstream stalls.

  logic [NUM_VOICES-1:0] active_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_q  [NUM_VOICES];

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [6:0]       note_lat_q, note_lat_d;
  logic             on_lat_q, on_lat_d;
  logic             match_found_q, match_found_d;
  logic [PTR_W-1:0] match_idx_q, match_idx_d;
  logic             free_found_q, free_found_d;
  logic [PTR_W-1:0] free_idx_q, free_idx_d;
  logic [PTR_W-1:0] oldest_idx_q, oldest_idx_d;
  logic [AGE_W-1:0] oldest_age_q, oldest_age_d;
  logic             flag_q, flag_d;
  logic             status_q, status_d;
  logic [PTR_W-1:0] vidx_q, vidx_d;
  logic [6:0]       note_num_q, note_num_d;
  logic             overflow_q, overflow_d;

  logic             m_hit, f_hit, o_hit, last;
  logic             hit;
  logic [PTR_W-1:0] sel;

  assign m_hit = active_q[ptr_q] && (note_q[ptr_q] == note_lat_q);
  assign f_hit = !active_q[ptr_q];
  assign o_hit = age_q[ptr_q] > oldest_age_q;
  assign last  = (ptr_q == PTR_W'(NUM_VOICES - 1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    note_lat_d    = note_lat_q;
    on_lat_d      = on_lat_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    flag_d        = 1'b0;
    status_d      = status_q;
    vidx_d        = vidx_q;
    note_num_d    = note_num_q;
    overflow_d    = 1'b0;
    hit           = 1'b0;
    sel           = '0;
    case (state_q)
      S_IDLE: begin
        if (i_midi_valid) begin
          note_lat_d    = i_midi_note;
          on_lat_d      = i_midi_note_on && (i_midi_velocity != 7'd0);
          ptr_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          oldest_idx_d  = '0;
          oldest_age_d  = '0;
          state_d       = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (m_hit && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = ptr_q;
        end
        if (f_hit && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = ptr_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (o_hit) begin
          oldest_idx_d = ptr_q;
          oldest_age_d = age_q[ptr_q];
        end
        ptr_d = ptr_q + PTR_W'(1);
        if (last) begin
          state_d = S_IDLE;
          if (on_lat_q && match_found_d) begin
            hit = 1'b1;
            sel = match_idx_d;
          end else if (on_lat_q && free_found_d) begin
            hit = 1'b1;
            sel = free_idx_d;
          end else if (on_lat_q) begin
`ifdef VOICE_STEAL_EN
            hit = 1'b1;
            sel = oldest_idx_d;
`else
            overflow_d = 1'b1;
`endif
          end else if (match_found_d) begin
            hit = 1'b1;
            sel = match_idx_d;
          end
          if (hit) begin
            state_d    = S_ISSUE;
            flag_d     = 1'b1;
            status_d   = on_lat_q;
            vidx_d     = sel;
            note_num_d = note_lat_q;
          end
        end
      end
      S_ISSUE: state_d = S_DRAIN;
      S_DRAIN: begin
        if (i_pipeline_state == 2'd2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      note_lat_q    <= '0;
      on_lat_q      <= 1'b0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      oldest_idx_q  <= '0;
      oldest_age_q  <= '0;
      flag_q        <= 1'b0;
      status_q      <= 1'b0;
      vidx_q        <= '0;
      note_num_q    <= '0;
      overflow_q    <= 1'b0;
      active_q      <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      note_lat_q    <= note_lat_d;
      on_lat_q      <= on_lat_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
      flag_q        <= flag_d;
      status_q      <= status_d;
      vidx_q        <= vidx_d;
      note_num_q    <= note_num_d;
      overflow_q    <= overflow_d;
      // Table commits in the strobe cycle; only note-ons age the other voices.
      if (state_q == S_ISSUE) begin
        if (status_q) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (PTR_W'(i) == vidx_q) begin
              active_q[i] <= 1'b1;
              note_q[i]   <= note_lat_q;
              age_q[i]    <= '0;
            end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
              age_q[i] <= age_q[i] + AGE_W'(1);
            end
          end
        end else begin
          active_q[vidx_q] <= 1'b0;
        end
      end
    end
  end

  assign o_midi_ready  = (state_q == S_IDLE);
  assign o_note_flag   = flag_q;
  assign o_note_status = status_q;
  assign o_voice_index = 8'(vidx_q);
  assign o_note_num    = note_num_q;
  assign o_overflow    = overflow_q;
  assign o_fsm_state   = state_q;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc (16 voices); follows VOICE_STEAL_EN like the RTL.
module tb_midi_voice_alloc;
  logic       i_clk;
  logic       i_reset;
  logic       i_midi_valid;
  logic       o_midi_ready;
  logic       i_midi_note_on;
  logic [6:0] i_midi_note;
  logic [6:0] i_midi_velocity;
  logic [1:0] i_pipeline_state;
  logic       o_note_flag;
  logic       o_note_status;
  logic [7:0] o_voice_index;
  logic [6:0] o_note_num;
  logic       o_overflow;
  logic [1:0] o_fsm_state;

  int checks = 0;
  int errors = 0;

  midi_voice_alloc dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_midi_valid     (i_midi_valid),
    .o_midi_ready     (o_midi_ready),
    .i_midi_note_on   (i_midi_note_on),
    .i_midi_note      (i_midi_note),
    .i_midi_velocity  (i_midi_velocity),
    .i_pipeline_state (i_pipeline_state),
    .o_note_flag      (o_note_flag),
    .o_note_status    (o_note_status),
    .o_voice_index    (o_voice_index),
    .o_note_num       (o_note_num),
    .o_overflow       (o_overflow),
    .o_fsm_state      (o_fsm_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  // Drives one message at a negedge in IDLE; returns strobe latency (0 = none
  // within budget), first overflow cycle and number of overflow cycles.
  task automatic run_msg(input logic on, input logic [6:0] note, input logic [6:0] vel,
                         output int lat, output int ovf_cyc, output int ovf_n);
    i_midi_note_on  = on;
    i_midi_note     = note;
    i_midi_velocity = vel;
    i_midi_valid    = 1'b1;
    lat = 0;
    ovf_cyc = 0;
    ovf_n = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge i_clk);
      i_midi_valid = 1'b0;
      if (o_overflow) begin
        ovf_n++;
        if (ovf_cyc == 0) ovf_cyc = c;
      end
      if (o_note_flag) begin
        lat = c;
        break;
      end
    end
  endtask

  // Releases DRAIN: the update slot seen after the strobe cycle returns to IDLE.
  task automatic drain();
    i_pipeline_state = 2'd2;
    @(negedge i_clk);
    @(negedge i_clk);
    i_pipeline_state = 2'd0;
  endtask

  task automatic expect_strobe(input string tag, input logic on, input logic [6:0] note,
                               input logic [6:0] vel, input logic st, input logic [7:0] idx);
    int lat, oc, on_n;
    run_msg(on, note, vel, lat, oc, on_n);
    chk({tag, "_lat"}, lat, 17);
    chk({tag, "_status"}, o_note_status, st);
    chk({tag, "_index"}, o_voice_index, idx);
    chk({tag, "_note"}, o_note_num, note);
    chk({tag, "_ovf"}, on_n, 0);
    drain();
  endtask

  task automatic expect_silent(input string tag, input logic on, input logic [6:0] note,
                               input logic [6:0] vel, input int exp_ovf);
    int lat, oc, on_n;
    run_msg(on, note, vel, lat, oc, on_n);
    chk({tag, "_nostrobe"}, lat, 0);
    chk({tag, "_ovf_n"}, on_n, exp_ovf);
    if (exp_ovf != 0) chk({tag, "_ovf_cyc"}, oc, 17);
    chk({tag, "_ready"}, o_midi_ready, 1'b1);
  endtask

  initial begin
    int lat, oc, on_n, flags, ready_hi;
    i_reset = 1'b1;
    i_midi_valid = 1'b0;
    i_midi_note_on = 1'b0;
    i_midi_note = '0;
    i_midi_velocity = '0;
    i_pipeline_state = 2'd0;
    @(negedge i_clk);
    do_reset();

    // reset state
    chk("rst_ready", o_midi_ready, 1'b1);
    chk("rst_flag", o_note_flag, 1'b0);
    chk("rst_status", o_note_status, 1'b0);
    chk("rst_index", o_voice_index, 8'd0);
    chk("rst_note", o_note_num, 7'd0);
    chk("rst_ovf", o_overflow, 1'b0);
    chk("rst_state", o_fsm_state, 2'd0);

    // first note-on, then drain with an update slot in the strobe cycle (must be ignored)
    run_msg(1'b1, 7'd60, 7'd100, lat, oc, on_n);
    chk("on60_lat", lat, 17);
    chk("on60_status", o_note_status, 1'b1);
    chk("on60_index", o_voice_index, 8'd0);
    chk("on60_note", o_note_num, 7'd60);
    chk("on60_ready", o_midi_ready, 1'b0);
    i_pipeline_state = 2'd2;
    @(negedge i_clk);
    i_pipeline_state = 2'd0;
    chk("flag_one_cycle", o_note_flag, 1'b0);
    chk("drain_ready0", o_midi_ready, 1'b0);
    @(negedge i_clk);
    chk("drain_strict", o_midi_ready, 1'b0);
    chk("drain_state", o_fsm_state, 2'd3);
    chk("drain_idx_hold", o_voice_index, 8'd0);
    i_pipeline_state = 2'd2;
    @(negedge i_clk);
    i_pipeline_state = 2'd0;
    chk("drain_release", o_midi_ready, 1'b1);

    expect_strobe("on64", 1'b1, 7'd64, 7'd90, 1'b1, 8'd1);
    expect_strobe("off60", 1'b0, 7'd60, 7'd0, 1'b0, 8'd0);

    // duplicate note-on, velocity-0 note-on, unheld note-off
    do_reset();
    expect_strobe("ld10", 1'b1, 7'd10, 7'd50, 1'b1, 8'd0);
    expect_strobe("ld11", 1'b1, 7'd11, 7'd50, 1'b1, 8'd1);
    expect_strobe("ld12", 1'b1, 7'd12, 7'd50, 1'b1, 8'd2);
    expect_strobe("ld62", 1'b1, 7'd62, 7'd50, 1'b1, 8'd3);
    expect_strobe("dup11", 1'b1, 7'd11, 7'd70, 1'b1, 8'd1);
    expect_strobe("off11", 1'b0, 7'd11, 7'd0, 1'b0, 8'd1);
    expect_silent("off11_again", 1'b0, 7'd11, 7'd0, 0);
    expect_strobe("vel0_62", 1'b1, 7'd62, 7'd0, 1'b0, 8'd3);
    expect_silent("off99", 1'b0, 7'd99, 7'd0, 0);

    // reset during SEARCH aborts the strobe and empties the table
    i_midi_note_on = 1'b1;
    i_midi_note = 7'd13;
    i_midi_velocity = 7'd80;
    i_midi_valid = 1'b1;
    @(negedge i_clk);
    i_midi_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("mid_search_state", o_fsm_state, 2'd1);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    chk("abort_ready", o_midi_ready, 1'b1);
    chk("abort_flag", o_note_flag, 1'b0);
    chk("abort_status", o_note_status, 1'b0);
    chk("abort_index", o_voice_index, 8'd0);
    chk("abort_note", o_note_num, 7'd0);
    chk("abort_ovf", o_overflow, 1'b0);
    chk("abort_state", o_fsm_state, 2'd0);
    flags = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_note_flag) flags++;
    end
    chk("abort_no_strobe", flags, 0);
    expect_silent("off10_empty", 1'b0, 7'd10, 7'd0, 0);
    expect_strobe("on13_empty", 1'b1, 7'd13, 7'd80, 1'b1, 8'd0);

    // fill all voices, then one more note-on
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_msg(1'b1, 7'(40 + i), 7'd64, lat, oc, on_n);
      chk("fill_lat", lat, 17);
      chk("fill_index", o_voice_index, 8'(i));
      drain();
    end
`ifdef VOICE_STEAL_EN
    expect_strobe("steal70", 1'b1, 7'd70, 7'd64, 1'b1, 8'd0);
`else
    expect_silent("drop70", 1'b1, 7'd70, 7'd64, 1);
`endif

    // a strobe with no update slot keeps the block stalled
    run_msg(1'b0, 7'd41, 7'd0, lat, oc, on_n);
    chk("off41_lat", lat, 17);
    chk("off41_status", o_note_status, 1'b0);
    chk("off41_index", o_voice_index, 8'd1);
    flags = 0;
    ready_hi = 0;
    for (int c = 0; c < 100; c++) begin
      i_pipeline_state = 2'(c % 2);
      i_midi_valid = 1'b1;
      @(negedge i_clk);
      if (o_note_flag) flags++;
      if (o_midi_ready) ready_hi++;
    end
    i_midi_valid = 1'b0;
    i_pipeline_state = 2'd0;
    chk("stall_no_strobe", flags, 0);
    chk("stall_ready_low", ready_hi, 0);
    chk("stall_idx_hold", o_voice_index, 8'd1);
    drain();
    chk("stall_release", o_midi_ready, 1'b1);
    expect_silent("off41_cleared", 1'b0, 7'd41, 7'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
